// File: rtl/conv2d_window_scheduler.sv
// Walks every KxK window (stride 1, no padding) of an IMG_W x IMG_H map for NUM_FILT filters and drives the MAC.
// Optional abort input is enabled by defining CONV_SCHED_ABORT_EN.
module conv2d_window_scheduler #(
    parameter int IMG_W       = 48,
    parameter int IMG_H       = 48,
    parameter int K           = 3,
    parameter int NUM_FILT    = 8,
    parameter int IMG_ADDR_W  = 13,
    parameter int KERN_ADDR_W = 7,
    parameter int OUT_ADDR_W  = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   mac_done,
`ifdef CONV_SCHED_ABORT_EN
    input  logic                   abort,
`endif
    output logic                   mac_en,
    output logic [IMG_ADDR_W-1:0]  base_addr_img,
    output logic [KERN_ADDR_W-1:0] base_addr_kern,
    output logic [OUT_ADDR_W-1:0]  out_addr,
    output logic                   out_we,
    output logic                   busy,
    output logic                   frame_done
);

    localparam int OW     = IMG_W - K + 1;
    localparam int OH     = IMG_H - K + 1;
    localparam int COL_W  = $clog2(OW + 1);
    localparam int ROW_W  = $clog2(OH + 1);
    localparam int FILT_W = $clog2(NUM_FILT + 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RUN  = 3'd1,
        WB   = 3'd2,
        NEXT = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t            state;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [FILT_W-1:0] filt;
    logic              out_we_q;
    logic              abort_hit;
    logic              col_last;
    logic              row_last;
    logic              last_win;

    assign col_last = (col == COL_W'(OW - 1));
    assign row_last = (row == ROW_W'(OH - 1));
    assign last_win = col_last && row_last && (filt == FILT_W'(NUM_FILT - 1));

`ifdef CONV_SCHED_ABORT_EN
    assign abort_hit = abort && ((state == RUN) || (state == WB) || (state == NEXT));
    // The strobe is already registered high during WB, so an abort seen there must mask it directly.
    assign out_we    = out_we_q && !abort_hit;
`else
    assign abort_hit = 1'b0;
    assign out_we    = out_we_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            col            <= '0;
            row            <= '0;
            filt           <= '0;
            mac_en         <= 1'b0;
            out_we_q       <= 1'b0;
            busy           <= 1'b0;
            frame_done     <= 1'b0;
            base_addr_img  <= '0;
            base_addr_kern <= '0;
            out_addr       <= '0;
        end else if (abort_hit) begin
            state      <= IDLE;
            col        <= '0;
            row        <= '0;
            filt       <= '0;
            mac_en     <= 1'b0;
            out_we_q   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    frame_done <= 1'b0;
                    if (start) begin
                        col            <= '0;
                        row            <= '0;
                        filt           <= '0;
                        base_addr_img  <= '0;
                        base_addr_kern <= '0;
                        out_addr       <= '0;
                        mac_en         <= 1'b1;
                        busy           <= 1'b1;
                        state          <= RUN;
                    end
                end
                RUN: begin
                    if (mac_done) begin
                        mac_en   <= 1'b0;
                        out_we_q <= 1'b1;
                        state    <= WB;
                    end
                end
                WB: begin
                    out_we_q <= 1'b0;
                    if (last_win) begin
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        state      <= DONE;
                    end else begin
                        state <= NEXT;
                    end
                end
                NEXT: begin
                    // Row wrap jumps over the K-1 pixels that cannot host a window.
                    if (!col_last) begin
                        col           <= col + COL_W'(1);
                        base_addr_img <= base_addr_img + IMG_ADDR_W'(1);
                    end else if (!row_last) begin
                        col           <= '0;
                        row           <= row + ROW_W'(1);
                        base_addr_img <= base_addr_img + IMG_ADDR_W'(K);
                    end else begin
                        col            <= '0;
                        row            <= '0;
                        filt           <= filt + FILT_W'(1);
                        base_addr_img  <= '0;
                        base_addr_kern <= base_addr_kern + KERN_ADDR_W'(K * K);
                    end
                    out_addr <= out_addr + OUT_ADDR_W'(1);
                    mac_en   <= 1'b1;
                    state    <= RUN;
                end
                DONE: begin
                    frame_done <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv2d_window_scheduler.sv
// Directed bench for conv2d_window_scheduler on a 5x4 map, K=3, two filters (3x2 windows per filter).
module tb_conv2d_window_scheduler;

    localparam int IMG_W = 5;
    localparam int IMG_H = 4;
    localparam int K     = 3;
    localparam int NF    = 2;
    localparam int IAW   = 13;
    localparam int KAW   = 7;
    localparam int OAW   = 15;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           mac_done = 1'b0;
`ifdef CONV_SCHED_ABORT_EN
    logic           abort = 1'b0;
`endif
    logic           mac_en;
    logic [IAW-1:0] base_addr_img;
    logic [KAW-1:0] base_addr_kern;
    logic [OAW-1:0] out_addr;
    logic           out_we;
    logic           busy;
    logic           frame_done;

    conv2d_window_scheduler #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .NUM_FILT(NF),
        .IMG_ADDR_W(IAW), .KERN_ADDR_W(KAW), .OUT_ADDR_W(OAW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .mac_done(mac_done),
`ifdef CONV_SCHED_ABORT_EN
        .abort(abort),
`endif
        .mac_en(mac_en),
        .base_addr_img(base_addr_img),
        .base_addr_kern(base_addr_kern),
        .out_addr(out_addr),
        .out_we(out_we),
        .busy(busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int we_cnt = 0;
    int fd_cnt = 0;
    int fd_cyc = 0;
    int we_addr [128];
    int we_img  [128];
    int we_kern [128];
    int img_tab [6] = '{0, 1, 2, 5, 6, 7};

    // Strobe / frame_done recorder, sampled on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (out_we === 1'b1 && we_cnt < 128) begin
            we_addr[we_cnt] = int'(out_addr);
            we_img[we_cnt]  = int'(base_addr_img);
            we_kern[we_cnt] = int'(base_addr_kern);
            we_cnt++;
        end
        if (frame_done === 1'b1) begin
            fd_cnt++;
            fd_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_mac_en(input string tag);
        for (int i = 0; i < 30 && mac_en !== 1'b1; i++) tick();
        check(tag, 32'(mac_en), 32'd1);
    endtask

    task automatic run_window(input int stall, input string tag);
        logic [31:0] img0;
        wait_mac_en(tag);
        img0 = 32'(base_addr_img);
        for (int i = 0; i < stall; i++) begin
            tick();
            check("stall_mac_en", 32'(mac_en), 32'd1);
            check("stall_img", 32'(base_addr_img), img0);
        end
        mac_done = 1'b1;
        tick();
        mac_done = 1'b0;
    endtask

    task automatic wait_fd(input int prev, input string tag);
        for (int i = 0; i < 300 && fd_cnt == prev; i++) tick();
        check(tag, fd_cnt, prev + 1);
    endtask

    task automatic check_frame(input int base);
        for (int i = 0; i < 12; i++) begin
            check("frame_out_addr", we_addr[base+i], i);
            check("frame_img", we_img[base+i], img_tab[i%6]);
            check("frame_kern", we_kern[base+i], (i / 6) * 9);
        end
    endtask

    initial begin
        int base;
        int run0;

        // Reset state
        tick();
        tick();
        check("rst_mac_en", 32'(mac_en), 0);
        check("rst_out_we", 32'(out_we), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_out_addr", 32'(out_addr), 0);
        check("rst_img", 32'(base_addr_img), 0);
        check("rst_kern", 32'(base_addr_kern), 0);
        rst_n = 1'b1;
        tick();

        // Full frame, mac_done held high so each window completes in its first RUN cycle
        mac_done = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        run0 = cyc;
        check("p1_first_mac_en", 32'(mac_en), 1);
        check("p1_first_busy", 32'(busy), 1);
        wait_fd(0, "p1_frame_done");
        check("p1_fd_latency", fd_cyc - run0, 35);
        check("p1_busy_in_done", 32'(busy), 0);
        mac_done = 1'b0;
        tick();
        tick();
        check("p1_we_count", we_cnt, 12);
        check("p1_fd_once", fd_cnt, 1);
        check_frame(0);

        // Stall on window 4, spurious mac_done in IDLE and NEXT, spurious start mid-frame
        base = we_cnt;
        mac_done = 1'b1;
        tick();
        tick();
        mac_done = 1'b0;
        check("p2_idle_mac_en", 32'(mac_en), 0);
        check("p2_idle_no_we", we_cnt, base);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int w = 0; w < 12; w++) begin
            if (w == 5) start = 1'b1;
            run_window((w == 4) ? 10 : 0, "p2_window");
            start = 1'b0;
            if (w == 2) begin
                tick();
                mac_done = 1'b1;
                tick();
                mac_done = 1'b0;
            end
        end
        wait_fd(1, "p2_frame_done");
        tick();
        tick();
        check("p2_we_count", we_cnt - base, 12);
        check_frame(base);

        // Asynchronous reset during RUN of window 7
        base = we_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int w = 0; w < 7; w++) run_window(0, "p4_window");
        wait_mac_en("p4_w7_run");
        check("p4_w7_out_addr", 32'(out_addr), 7);
        check("p4_w7_img", 32'(base_addr_img), 1);
        check("p4_w7_kern", 32'(base_addr_kern), 9);
        rst_n = 1'b0;
        #1;
        check("p4_rst_mac_en", 32'(mac_en), 0);
        check("p4_rst_busy", 32'(busy), 0);
        check("p4_rst_out_addr", 32'(out_addr), 0);
        check("p4_rst_img", 32'(base_addr_img), 0);
        check("p4_rst_kern", 32'(base_addr_kern), 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("p4_partial_we", we_cnt - base, 7);
        check("p4_no_fd", fd_cnt, 2);
        base = we_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("p4_restart_mac_en", 32'(mac_en), 1);
        check("p4_restart_out_addr", 32'(out_addr), 0);
        check("p4_restart_img", 32'(base_addr_img), 0);
        for (int w = 0; w < 12; w++) run_window(0, "p4b_window");
        wait_fd(2, "p4_frame_done");
        tick();
        tick();
        check_frame(base);

        // Back-to-back frames with start held high
        base = we_cnt;
        mac_done = 1'b1;
        start = 1'b1;
        tick();
        wait_fd(3, "p5_fd1");
        check("p5_done_busy", 32'(busy), 0);
        tick();
        check("p5_idle_busy", 32'(busy), 0);
        tick();
        check("p5_restart_busy", 32'(busy), 1);
        check("p5_restart_mac_en", 32'(mac_en), 1);
        check("p5_restart_out_addr", 32'(out_addr), 0);
        start = 1'b0;
        wait_fd(4, "p5_fd2");
        mac_done = 1'b0;
        tick();
        tick();
        check("p5_we_count", we_cnt - base, 24);
        check("p5_second_first", we_addr[base+12], 0);
        check("p5_second_last", we_addr[base+23], 11);
        check("p5_idle_busy_end", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
